mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
// Load/store front end between execute stage and word-addressed data RAM. Converts alucode/addr/w_data
// into word address, byte enables and lane-shifted write data; extracts, sign/zero-extends and registers
// load data. Misaligned LW/LH/LHU/SW/SH are split into two word accesses, stalling the pipeline one cycle.
// PARAMETERS
// WORD_AW  15  word-address width; word index = addr[WORD_AW+1:2], RAM depth 2**WORD_AW words
// PORTS
// clk        in   1   clock, all state on rising edge
// rst        in   1   synchronous, active-high reset
// is_load    in   1   decoder: load request this cycle
// is_store   in   1   decoder: store request this cycle
// alucode    in   6   `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW from define.vh
// addr       in   32  byte address from ALU
// w_data     in   32  store data (rs2)
// stall      out  1   request held; upstream keeps inputs and does not advance
// resp_valid out  1   registered 1-cycle pulse: r_data holds a completed load
// r_data     out  32  registered load result, extended per alucode
// mem_addr   out  WORD_AW  word index to RAM (combinational)
// mem_we     out  1   RAM write strobe (combinational)
// mem_be     out  4   byte enables, bit i = byte lane i (bits [8i+7:8i])
// mem_wdata  out  32  lane-shifted store data
// mem_rdata  in   32  RAM read word, combinational (async read) for mem_addr
// BEHAVIOUR
// - Reset: state=IDLE, stall=0, resp_valid=0, r_data=0, hold regs=0; mem_we=0 while rst=1.
// - Valid request: exactly one of is_load/is_store with matching alucode. Both high, or alucode not a
//   load/store: no access (mem_we=0, be=0), no resp, no stall.
// - off=addr[1:0], w=addr[WORD_AW+1:2]; size 1/2/4 bytes. Misaligned: off+size>4 (LH/LHU/SH off=3; LW/SW off!=0).
//   Byte accesses never misaligned.
// - IDLE, aligned: mem_addr=w; store: mem_we=1, mem_be = size-mask<<off, mem_wdata = w_data<<(8*off).
//   Load: bytes [off+size-1:off] of mem_rdata extended (LB/LH sign, LBU/LHU zero, LW as-is) into r_data;
//   resp_valid=1 next cycle. stall=0; back-to-back requests accepted every cycle.
// - IDLE, misaligned: first half, same cycle: mem_addr=w, lanes off..3 (be=4'b1111<<off), wdata=w_data<<(8*off);
//   load bytes captured into hold reg. Latch alucode, w, off, w_data. stall=1. Next state SECOND.
// - SECOND: mem_addr=(w+1) mod 2**WORD_AW (wraps 2**WORD_AW-1 -> 0); lanes 0..off+size-5,
//   be=(4'b1111>>(8-off-size)) for that range, wdata=w_data>>(8*(4-off)). Uses latched values only.
//   Load: combine hold (low bytes) and mem_rdata (high bytes), extend, r_data next edge, resp_valid=1.
//   stall=0; inputs this cycle are the held request and are ignored; next state IDLE.
// - Stores never assert resp_valid. r_data holds last load value until next load completes.
// - Reset in SECOND: abort, return to IDLE; first half already written, second half not written.
// - Load total latency: aligned 1 cycle, misaligned 2 cycles, from request to resp_valid.
// TESTING
// - RAM[5]=0x8899AABB; LB addr=0x16 -> r_data=0xFFFFFF99, resp_valid pulse next cycle, stall never high.
// - LW addr=0x15 with RAM[5]=0x44332211, RAM[6]=0x88776655 -> stall 1 cycle, r_data=0x55443322 after 2 cycles.
// - SW 0xDEADBEEF addr=0x1B -> cycle1 word 6 be=1000 lane3=0xEF; cycle2 word 7 be=0111 data 0xDEADBE low 3 lanes.
// - LHU addr=0x1FFFF (word 32767, off 3), RAM[32767]=0xAB000000, RAM[0]=0x000000CD -> r_data=0x0000CDAB.
// - SB/SH/SW aligned back-to-back every cycle, then LW each word -> exact merged contents, no stall.
// - Misaligned SW, rst=1 during SECOND -> first word written only, state IDLE, resp_valid=0, r_data=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front end between the execute stage and a word-addressed data RAM.
// Misaligned word/half accesses are split into two word accesses with a one-cycle stall.
package mem_access_pkg;
  localparam logic [5:0] ALU_LB  = 6'd16;
  localparam logic [5:0] ALU_LH  = 6'd17;
  localparam logic [5:0] ALU_LW  = 6'd18;
  localparam logic [5:0] ALU_LBU = 6'd19;
  localparam logic [5:0] ALU_LHU = 6'd20;
  localparam logic [5:0] ALU_SB  = 6'd21;
  localparam logic [5:0] ALU_SH  = 6'd22;
  localparam logic [5:0] ALU_SW  = 6'd23;
endpackage

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int WORD_AW = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               is_load,
  input  logic               is_store,
  input  logic [5:0]         alucode,
  input  logic [31:0]        addr,
  input  logic [31:0]        w_data,
  output logic               stall,
  output logic               resp_valid,
  output logic [31:0]        r_data,
  output logic [WORD_AW-1:0] mem_addr,
  output logic               mem_we,
  output logic [3:0]         mem_be,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic {IDLE, SECOND} state_e;

  state_e             state_q, state_d;
  logic [5:0]         lat_code;
  logic [WORD_AW-1:0] lat_w;
  logic [1:0]         lat_off;
  logic [31:0]        lat_wdata;
  logic [31:0]        hold_q;

  logic [5:0]  cur_code;
  logic [1:0]  cur_off;
  logic        code_ld, code_st, sign_ext;
  logic [2:0]  size_b;
  logic [3:0]  size_mask;
  logic [3:0]  end_byte;
  logic        split;
  logic        req_ld, req_st;
  logic [4:0]  sh_lo;
  logic [5:0]  sh_hi;
  logic        we_raw, load_done, capture;
  logic [31:0] load_word;
  logic        addr_unused;

  // Only the word-index and offset bits of the byte address reach the RAM.
  assign addr_unused = ^addr[31:WORD_AW+2];

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] nb,
                                         input logic sx);
    case (nb)
      3'd1:    extend = {{24{sx & d[7]}}, d[7:0]};
      3'd2:    extend = {{16{sx & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // During the second half the decode runs on the latched request, not the live inputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    cur_code  = (state_q == SECOND) ? lat_code : alucode;
    cur_off   = (state_q == SECOND) ? lat_off  : addr[1:0];
    code_ld   = 1'b0;
    code_st   = 1'b0;
    sign_ext  = 1'b0;
    size_b    = 3'd4;
    case (cur_code)
      ALU_LB:  begin code_ld = 1'b1; size_b = 3'd1; sign_ext = 1'b1; end
      ALU_LH:  begin code_ld = 1'b1; size_b = 3'd2; sign_ext = 1'b1; end
      ALU_LW:  begin code_ld = 1'b1; size_b = 3'd4; end
      ALU_LBU: begin code_ld = 1'b1; size_b = 3'd1; end
      ALU_LHU: begin code_ld = 1'b1; size_b = 3'd2; end
      ALU_SB:  begin code_st = 1'b1; size_b = 3'd1; end
      ALU_SH:  begin code_st = 1'b1; size_b = 3'd2; end
      ALU_SW:  begin code_st = 1'b1; size_b = 3'd4; end
      default: ;
    endcase
    case (size_b)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    end_byte = {2'b00, cur_off} + {1'b0, size_b};
    split    = end_byte > 4'd4;
    req_ld   = is_load & ~is_store & code_ld;
    req_st   = is_store & ~is_load & code_st;
    sh_lo    = {cur_off, 3'b000};
    sh_hi    = 6'd32 - {1'b0, cur_off, 3'b000};
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_addr  = addr[WORD_AW+1:2];
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    we_raw    = 1'b0;
    load_done = 1'b0;
    capture   = 1'b0;
    load_word = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_ld || req_st) begin
          // Truncation to four lanes gives the first-half mask for split accesses too.
          mem_be    = size_mask << cur_off;
          mem_wdata = w_data << sh_lo;
          we_raw    = req_st;
          if (split) begin
            stall   = 1'b1;
            capture = 1'b1;
            state_d = SECOND;
          end else begin
            load_done = req_ld;
            load_word = mem_rdata >> sh_lo;
          end
        end
      end
      SECOND: begin
        mem_addr  = lat_w + WORD_AW'(1);
        mem_be    = 4'b1111 >> (4'd8 - end_byte);
        mem_wdata = lat_wdata >> sh_hi;
        we_raw    = code_st;
        load_done = code_ld;
        load_word = hold_q | (mem_rdata << sh_hi);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  // Gating the strobe with reset keeps an aborted split store from writing its second half.
  assign mem_we = we_raw & ~rst;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments to avoid ordering races.
    if (rst) begin
      state_q    <= IDLE;
      resp_valid <= 1'b0;
      r_data     <= 32'h0;
      lat_code   <= 6'h0;
      lat_w      <= '0;
      lat_off    <= 2'b00;
      lat_wdata  <= 32'h0;
      hold_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      resp_valid <= load_done;
      if (load_done) r_data <= extend(load_word, size_b, sign_ext);
      if (capture) begin
        lat_code  <= alucode;
        lat_w     <= addr[WORD_AW+1:2];
        lat_off   <= addr[1:0];
        lat_wdata <= w_data;
        hold_q    <= mem_rdata >> sh_lo;
      end
    end
  end

endmodule
